// File: rtl/fifo_ctl_4x8_if.sv
// Push/pop handshake and register-file port bundle for the 4-entry FIFO controller.
// The controller takes the slave side; producer, consumer and register file sit on the master side.
interface fifo_ctl_4x8_if #(parameter int W = 8);
    logic           push;
    logic [W-1:0]   din;
    logic           pop;
    logic [W-1:0]   dout;
    logic           dout_vld;
    logic           full;
    logic           empty;
    logic [2:0]     count;
    logic           ovf;
    logic           udf;
    logic           rf_wr_e;
    logic [1:0]     rf_wr_addr;
    logic [W-1:0]   rf_wr_data;
    logic [1:0]     rf_rd_addr;
    logic [W-1:0]   rf_rd_data;

    modport master (
        output push, din, pop, rf_rd_data,
        input  dout, dout_vld, full, empty, count, ovf, udf,
               rf_wr_e, rf_wr_addr, rf_wr_data, rf_rd_addr
    );

    modport slave (
        input  push, din, pop, rf_rd_data,
        output dout, dout_vld, full, empty, count, ovf, udf,
               rf_wr_e, rf_wr_addr, rf_wr_data, rf_rd_addr
    );
endinterface

// File: rtl/fifo_ctl_4x8.sv
// 4-entry FIFO controller using an external 4x8 register file as storage.
// Owns pointers, occupancy, flags and the registered output word.
module fifo_ctl_4x8 (
    input logic            clk,
    input logic            rst,
    fifo_ctl_4x8_if.slave  bus
);
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic [7:0] dout_q, dout_d;
    logic       dout_vld_q, dout_vld_d;
    logic       ovf_q, ovf_d;
    logic       udf_q, udf_d;
    logic       full, empty, push_acc, pop_acc;

    assign full  = (count_q == 3'd4);
    assign empty = (count_q == 3'd0);

    // A push into a full FIFO is legal only when a pop frees the head slot in the same cycle.
    assign pop_acc  = bus.pop & ~empty;
    assign push_acc = bus.push & (~full | pop_acc);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        dout_d     = dout_q;
        dout_vld_d = 1'b0;
        ovf_d      = ovf_q;
        udf_d      = udf_q;

        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + 2'd1;
        end
        if (pop_acc) begin
            rd_ptr_d   = rd_ptr_q + 2'd1;
            dout_d     = bus.rf_rd_data;
            dout_vld_d = 1'b1;
        end

        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase

        if (bus.push & ~push_acc) begin
            ovf_d = 1'b1;
        end
        if (bus.pop & ~pop_acc) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            dout_q     <= 8'd0;
            dout_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    // Reset must suppress the write strobe so a reset cycle never disturbs storage.
    assign bus.rf_wr_e    = push_acc & ~rst;
    assign bus.rf_wr_addr = wr_ptr_q;
    assign bus.rf_wr_data = bus.din;
    assign bus.rf_rd_addr = rd_ptr_q;

    assign bus.dout     = dout_q;
    assign bus.dout_vld = dout_vld_q;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = count_q;
    assign bus.ovf      = ovf_q;
    assign bus.udf      = udf_q;
endmodule
